// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the PT1_CPU register-file access scheduler.
package regfile_sched_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 4;
   localparam int NREG   = 16;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_MOVE  = 2'b10,
      OP_SWAP  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_MV,
      S_SW_CAP,
      S_SW_MV,
      S_SW_WB,
      S_RESP
   } state_t;

   // Converts a register index into the register file's one-hot load vector.
   function automatic logic [NREG-1:0] onehot16(input logic [REG_AW-1:0] idx);
      logic [NREG-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/regfile_access_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt,
   output logic       ptr
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // After a grant, priority passes to the requester that did not win.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= RR_INIT;
      else if (update)
         ptr <= ~gnt[1];
   end

endmodule

// File: rtl/regfile_access_sched.sv
// Sequences READ/WRITE/MOVE/SWAP operations from two requesters onto the
// single write path of the 16x16 register file.
module regfile_access_sched
   import regfile_sched_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int NREG    = 16,
   parameter int RR_INIT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [3:0]             req_op,
   input  logic [7:0]             req_src,
   input  logic [7:0]             req_dst,
   input  logic [2*DATA_W-1:0]    req_wdata,
   output logic [1:0]             rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   input  logic [NREG*DATA_W-1:0] rf_outs,
   output logic [REG_AW:0]        rf_sel,
   output logic [REG_AW-1:0]      rf_waddr,
   output logic [DATA_W-1:0]      rf_data,
   output logic [NREG-1:0]        rf_load
);

   state_t              state, state_nxt;
   logic                cur_id;
   op_t                 cur_op, new_op;
   logic [REG_AW-1:0]   cur_src, cur_dst;
   logic [DATA_W-1:0]   cur_wdata, result, temp;
   logic [DATA_W-1:0]   regs [NREG];
   logic [1:0]          gnt;
   logic                ptr_unused;
   logic                accept, win;

   always_comb begin
      for (int i = 0; i < NREG; i++)
         regs[i] = rf_outs[i*DATA_W +: DATA_W];
   end

   // Grants are only offered while idle and out of reset.
   assign accept    = (state == S_IDLE) && !reset && (req_valid != 2'b00);
   assign req_ready = accept ? gnt : 2'b00;
   assign win       = gnt[1];
   assign new_op    = op_t'(win ? req_op[3:2] : req_op[1:0]);

   rr_arb2 #(.RR_INIT(RR_INIT != 0)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req_valid),
      .update (accept),
      .gnt    (gnt),
      .ptr    (ptr_unused)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cur_id    <= 1'b0;
         cur_op    <= OP_READ;
         cur_src   <= '0;
         cur_dst   <= '0;
         cur_wdata <= '0;
         result    <= '0;
         temp      <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cur_id    <= win;
            cur_op    <= new_op;
            cur_src   <= win ? req_src[7:4] : req_src[3:0];
            cur_dst   <= win ? req_dst[7:4] : req_dst[3:0];
            cur_wdata <= win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
         end
         // WRITE and MOVE report the destination value they overwrite.
         case (state)
            S_RD:        result <= regs[cur_src];
            S_WR, S_MV:  result <= regs[cur_dst];
            S_SW_CAP: begin
               temp   <= regs[cur_src];
               result <= regs[cur_src];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      rf_sel    = '0;
      rf_waddr  = '0;
      rf_data   = '0;
      rf_load   = '0;
      rsp_valid = 2'b00;
      rsp_rdata = '0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (new_op)
                  OP_READ:  state_nxt = S_RD;
                  OP_WRITE: state_nxt = S_WR;
                  OP_MOVE:  state_nxt = S_MV;
                  default:  state_nxt = S_SW_CAP;
               endcase
            end
         end
         S_RD: begin
            rf_sel    = {1'b0, cur_src};
            state_nxt = S_RESP;
         end
         S_WR: begin
            rf_sel    = {1'b1, cur_src};
            rf_data   = cur_wdata;
            rf_waddr  = cur_dst;
            rf_load   = onehot16(cur_dst);
            state_nxt = S_RESP;
         end
         S_MV: begin
            rf_sel    = {1'b0, cur_src};
            rf_waddr  = cur_dst;
            rf_load   = onehot16(cur_dst);
            state_nxt = S_RESP;
         end
         S_SW_CAP: state_nxt = S_SW_MV;
         // The register file routes old dst into src; temp then restores dst.
         S_SW_MV: begin
            rf_sel    = {1'b0, cur_dst};
            rf_waddr  = cur_src;
            rf_load   = onehot16(cur_src);
            state_nxt = S_SW_WB;
         end
         S_SW_WB: begin
            rf_sel    = {1'b1, {REG_AW{1'b0}}};
            rf_data   = temp;
            rf_waddr  = cur_dst;
            rf_load   = onehot16(cur_dst);
            state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = cur_id ? 2'b10 : 2'b01;
            rsp_rdata = result;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: doc/regfile_access_sched.md
Name: regfile_access_sched

Overview:
- Sequencer and arbiter for the 16x16 register file in PT1_CPU.
- Shares the register file's single write path between two requesters: 0 = execute unit, 1 = debug/load port.
- Uses round-robin arbitration and a valid/ready request handshake with a one-cycle response pulse.
- Drives the register file's 5-bit read/select address, write data and one-hot load lines, and reads the packed 256-bit register bus.
- Provides READ, WRITE, MOVE and multi-cycle SWAP operations.

Parameters:
- DATA_W, 16, register width.
- NREG, 16, number of registers; the address width is 4.
- RR_INIT, 0, requester holding priority after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted (one-hot or zero).
- req_op  in  4  2 bits per requester: 00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
- req_src  in  8  4-bit source register index per requester.
- req_dst  in  8  4-bit destination register index per requester.
- req_wdata  in  32  16-bit write data per requester.
- rsp_valid  out  2  one-cycle response pulse to the owning requester.
- rsp_rdata  out  16  response data; meaningful only when rsp_valid is nonzero.
- rf_outs  in  256  register file contents; register i occupies bits [16i+15:16i].
- rf_sel  out  5  register file read/select address; bit4 = 1 selects rf_data, otherwise register [3:0].
- rf_waddr  out  4  register file write address.
- rf_data  out  16  register file external data input.
- rf_load  out  16  one-hot load enable, or all zero.

Behaviour:
- Reset, checked at every posedge:
  - State goes to IDLE; rr pointer = RR_INIT.
  - All outputs are 0, including rf_load, req_ready and rsp_valid.
  - Reset mid-SWAP aborts the operation. Register writes already committed stay; no rollback.
- States: IDLE, RD, WR, MV, SW_CAP, SW_MV, SW_WB, RESP.
- IDLE:
  - req_ready is combinational and one-hot, asserted only for the arbitration winner.
  - Winner rules: the single valid requester wins; if both are valid, the rr pointer wins.
  - On accept, latch id/op/src/dst/wdata, set rr pointer = other id, and go to the op state.
- RD (1 cycle): rf_sel={0,src}; capture rf_outs[src] into the result register. Next state RESP.
- WR (1 cycle): rf_sel={1,src}, rf_data=wdata, rf_waddr=dst, rf_load=1<<dst. Result = old dst value. Next state RESP.
- MV (1 cycle): rf_sel={0,src}, rf_waddr=dst, rf_load=1<<dst. The register file routes src into dst. Result = old dst value. Next state RESP.
- SWAP:
  - SW_CAP: temp = rf_outs[src]; no load.
  - SW_MV: rf_sel={0,dst}, rf_load=1<<src, so src receives the old dst.
  - SW_WB: rf_sel={1,0}, rf_data=temp, rf_load=1<<dst.
  - Result = old src value. Next state RESP.
- src==dst: every op still executes. MOVE and SWAP leave contents unchanged; the result is the unchanged value.
- RESP:
  - rsp_valid[id]=1 for exactly one cycle; rsp_rdata=result.
  - No accept in this cycle. Next state IDLE.
- Latency from the accept cycle T:
  - READ/WRITE/MOVE: response in cycle T+2, next accept no earlier than T+3.
  - SWAP: response in T+4.
- Outputs outside the active states:
  - rf_load = 0 in IDLE, RD, SW_CAP and RESP.
  - rf_sel, rf_waddr and rf_data hold 0 when not in use.
- Requester rules:
  - Request fields must be held stable while req_valid is high and unaccepted.
  - A requester must not drop req_valid before acceptance; if it does, no request is latched.
- Starvation: with both requesters continuously valid, grants strictly alternate.

Decomposition:
- Package regfile_sched_pkg holds:
  - op_t enum (READ, WRITE, MOVE, SWAP).
  - state_t enum.
  - DATA_W, REG_AW=4, NREG.
  - Function onehot16(idx).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], a pointer-update strobe.
  - Outputs: gnt[1:0], pointer; reset pointer = RR_INIT.

Test Plan:
- WRITE then READ:
  - req0 WRITE dst=5 wdata=16'hBEEF, then req0 READ src=5.
  - Required: rf_load=16'h0020 for one cycle; rsp_rdata=16'hBEEF at T+2 of the READ.
- MOVE:
  - Preload r3=16'h1234, r9=16'h0000; req1 MOVE src=3 dst=9.
  - Required: rf_sel=5'b00011, rf_load=16'h0200; r9 becomes 16'h1234; rsp_rdata=16'h0000.
- SWAP:
  - r2=16'hAAAA, r7=16'h5555; req0 SWAP src=2 dst=7.
  - Required: r2=16'h5555, r7=16'hAAAA; rsp_valid=2'b01 at T+4; rsp_rdata=16'hAAAA.
- Contention:
  - Both requesters hold READ continuously from reset with RR_INIT=0.
  - Required: grants go 0,1,0,1; no requester waits more than one other op.
- Reset mid-SWAP:
  - Assert reset in the SW_MV cycle.
  - Required: next cycle all outputs 0 and state IDLE; r(src) holds the value written in SW_MV; no rsp_valid.
- src==dst SWAP:
  - r4=16'h00FF; SWAP src=dst=4.
  - Required: r4 stays 16'h00FF; rsp_rdata=16'h00FF.
